fp_vec_mul_sequencer: RTL and testbench

//   Sequencer that sits directly around the single-precision `multiplier` core:
//   it drives the core's input_a/input_b stb/ack ports and drains its output_z port.
//   Two operand vectors A and B are loaded into local buffers. On start, it issues
//   A[i]*B[i] for i=0..len-1 one pair at a time and stores each product in R[i].
//   It raises done when the vector is complete.

---
 rtl/fp_vec_mul_sequencer.sv | 169 ++++++++++++++++
 tb/tb_fp_vec_mul_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_vec_mul_sequencer.sv
// Vector multiply sequencer around a single-precision stb/ack multiplier core.
// Loads operand buffers A/B, issues A[i]*B[i] one pair at a time, captures
// each product into R[i] and pulses done when the vector is complete.
module fp_vec_mul_sequencer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic             wr_sel_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW:0]      len_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [WIDTH-1:0] mul_a_o,
  output logic             mul_a_stb_o,
  input  logic             mul_a_ack_i,
  output logic [WIDTH-1:0] mul_b_o,
  output logic             mul_b_stb_o,
  input  logic             mul_b_ack_i,
  input  logic [WIDTH-1:0] prod_z_i,
  input  logic             prod_z_stb_i,
  output logic             prod_z_ack_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_COLLECT, S_DONE} state_e;

  state_e                      state_q, state_d;
  logic [AW-1:0]               idx_q, idx_d, idx_nxt;
  logic [AW:0]                 len_q, len_d;
  logic                        a_sent_q, a_sent_d, b_sent_q, b_sent_d;
  logic                        a_stb_q, a_stb_d, b_stb_q, b_stb_d, z_ack_q, z_ack_d;
  logic                        busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [WIDTH-1:0]            mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [DEPTH-1:0][WIDTH-1:0] a_mem_q, b_mem_q, r_mem_q;
  logic                        a_xfer, b_xfer, z_xfer, len_ok, last, pair_sent;

  assign a_xfer    = a_stb_q & mul_a_ack_i;
  assign b_xfer    = b_stb_q & mul_b_ack_i;
  assign z_xfer    = z_ack_q & prod_z_stb_i;
  assign pair_sent = (a_sent_q | a_xfer) & (b_sent_q | b_xfer);
  assign len_ok    = (len_i != '0) && (len_i <= (AW+1)'(DEPTH));
  assign last      = ({1'b0, idx_q} == len_q - (AW+1)'(1));
  assign idx_nxt   = idx_q + AW'(1);

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign mul_a_o      = mul_a_q;
  assign mul_b_o      = mul_b_q;
  assign mul_a_stb_o  = a_stb_q;
  assign mul_b_stb_o  = b_stb_q;
  assign prod_z_ack_o = z_ack_q;
  assign rd_data_o    = r_mem_q[rd_addr_i];

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; an illegal length skips straight to DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_i) state_d = len_ok ? S_ISSUE : S_DONE;
      S_ISSUE:   if (pair_sent) state_d = S_COLLECT;
      S_COLLECT: if (z_xfer) state_d = last ? S_DONE : S_ISSUE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and sequencing counters
  always_comb begin
    idx_d    = idx_q;
    len_d    = len_q;
    a_sent_d = a_sent_q;
    b_sent_d = b_sent_q;
    a_stb_d  = a_stb_q;
    b_stb_d  = b_stb_q;
    z_ack_d  = z_ack_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        len_d = len_i;
        idx_d = '0;
        err_d = 1'b0;
        if (len_ok) begin
          busy_d   = 1'b1;
          a_stb_d  = 1'b1;
          b_stb_d  = 1'b1;
          a_sent_d = 1'b0;
          b_sent_d = 1'b0;
          mul_a_d  = a_mem_q[0];
          mul_b_d  = b_mem_q[0];
        end
      end
      S_ISSUE: begin
        // each port drops its own strobe on its own transfer edge
        if (a_xfer) begin a_stb_d = 1'b0; a_sent_d = 1'b1; end
        if (b_xfer) begin b_stb_d = 1'b0; b_sent_d = 1'b1; end
        if (pair_sent) begin a_sent_d = 1'b0; b_sent_d = 1'b0; end
      end
      S_COLLECT: begin
        // ack only after the product strobe has been observed
        if (prod_z_stb_i && !z_ack_q) z_ack_d = 1'b1;
        if (z_xfer) begin
          z_ack_d = 1'b0;
          if (!last) begin
            idx_d   = idx_nxt;
            a_stb_d = 1'b1;
            b_stb_d = 1'b1;
            mul_a_d = a_mem_q[idx_nxt];
            mul_b_d = b_mem_q[idx_nxt];
          end
        end
      end
      S_DONE: begin
        done_d = 1'b1;
        busy_d = 1'b0;
        err_d  = (len_q == '0) || (len_q > (AW+1)'(DEPTH));
      end
      default: ;
    endcase
  end

  // Registered outputs and counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= '0; len_q <= '0; a_sent_q <= 1'b0; b_sent_q <= 1'b0;
      a_stb_q <= 1'b0; b_stb_q <= 1'b0; z_ack_q <= 1'b0;
      busy_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0;
      mul_a_q <= '0; mul_b_q <= '0;
    end else begin
      idx_q <= idx_d; len_q <= len_d; a_sent_q <= a_sent_d; b_sent_q <= b_sent_d;
      a_stb_q <= a_stb_d; b_stb_q <= b_stb_d; z_ack_q <= z_ack_d;
      busy_q <= busy_d; done_q <= done_d; err_q <= err_d;
      mul_a_q <= mul_a_d; mul_b_q <= mul_b_d;
    end
  end

  // Operand loads in IDLE only; one result capture per product handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_mem_q <= '0;
      b_mem_q <= '0;
      r_mem_q <= '0;
    end else begin
      if (state_q == S_IDLE && wr_en_i) begin
        if (wr_sel_i) b_mem_q[wr_addr_i] <= wr_data_i;
        else          a_mem_q[wr_addr_i] <= wr_data_i;
      end
      if (state_q == S_COLLECT && z_xfer) r_mem_q[idx_q] <= prod_z_i;
    end
  end

endmodule

// File: tb/tb_fp_vec_mul_sequencer.sv
// Bench for fp_vec_mul_sequencer: behavioural multiplier responder, vector-level
// reference model and a per-cycle protocol/scoreboard checker.
module tb_fp_vec_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, wr_sel, start;
  logic [2:0]  wr_addr, rd_addr;
  logic [31:0] wr_data, rd_data;
  logic [3:0]  len_v;
  logic        busy, done, err;
  logic [31:0] mul_a, mul_b, z;
  logic        mul_a_stb, mul_b_stb, a_ack, b_ack, z_stb, prod_z_ack;

  int n_tests = 0, n_fail = 0;

  fp_vec_mul_sequencer #(.WIDTH(32), .DEPTH(8), .AW(3)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wr_en_i(wr_en), .wr_sel_i(wr_sel), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .len_i(len_v), .start_i(start),
    .busy_o(busy), .done_o(done), .err_o(err),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .mul_a_o(mul_a), .mul_a_stb_o(mul_a_stb), .mul_a_ack_i(a_ack),
    .mul_b_o(mul_b), .mul_b_stb_o(mul_b_stb), .mul_b_ack_i(b_ack),
    .prod_z_i(z), .prod_z_stb_i(z_stb), .prod_z_ack_o(prod_z_ack)
  );

  always #5 clk = ~clk;

  // ---------------- float helpers (normal numbers, exact products) ----------
  function automatic real sp2r(input logic [31:0] a);
    logic [63:0] d;
    if (a[30:0] == 31'd0) return 0.0;
    d = {a[31], 3'b000, a[30:23], a[22:0], 29'd0};
    d[62:52] = {3'b000, a[30:23]} + 11'd896;
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] sp_mul(input logic [31:0] a, input logic [31:0] b);
    return r2sp(sp2r(a) * sp2r(b));
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [7:0] e;
    logic [3:0] m;
    e = 8'($urandom_range(120, 134));
    m = 4'($urandom);
    return {1'($urandom), e, m, 19'd0};
  endfunction

  // ---------------- comparison bookkeeping ----------------------------------
  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // ---------------- multiplier core responder -------------------------------
  // ord: 0 = a then b, 1 = b then a, 2 = both acks together
  int a_dly = 0, b_dly = 0, z_dly = 3, ord = 0;
  int ph, cnt;
  logic got_a, got_b;
  logic [31:0] ra, rb;
  wire m_xa = a_ack & mul_a_stb;
  wire m_xb = b_ack & mul_b_stb;
  wire m_ga = got_a | m_xa;
  wire m_gb = got_b | m_xb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_ack <= 1'b0; b_ack <= 1'b0; z_stb <= 1'b0; z <= '0;
      ph <= 0; cnt <= 0; got_a <= 1'b0; got_b <= 1'b0; ra <= '0; rb <= '0;
    end else begin
      case (ph)
        0: begin
          if (m_xa) begin ra <= mul_a; a_ack <= 1'b0; end
          if (m_xb) begin rb <= mul_b; b_ack <= 1'b0; end
          got_a <= m_ga;
          got_b <= m_gb;
          if (m_ga && m_gb) begin
            ph <= 1; cnt <= z_dly; got_a <= 1'b0; got_b <= 1'b0;
          end else if (m_xa || m_xb) cnt <= b_dly;
          else if (cnt != 0) cnt <= cnt - 1;
          else begin
            if (!m_ga && !a_ack && (ord != 1 || m_gb)) a_ack <= 1'b1;
            if (!m_gb && !b_ack && (ord != 0 || m_ga)) b_ack <= 1'b1;
          end
        end
        1: begin
          if (cnt != 0) cnt <= cnt - 1;
          else begin z <= sp_mul(ra, rb); z_stb <= 1'b1; ph <= 2; end
        end
        2: if (z_stb && prod_z_ack) begin z_stb <= 1'b0; ph <= 0; cnt <= a_dly; end
        default: ph <= 0;
      endcase
    end
  end

  // ---------------- reference model -----------------------------------------
  logic [31:0] exp_A [8], exp_B [8], exp_R [8];
  logic [31:0] L_A [8] = '{32'h3F800000, 32'h40000000, 32'hC0400000, 32'hC0800000,
                           32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
  logic [31:0] L_B [8] = '{32'hC0800000, 32'h40400000, 32'h40000000, 32'hBF800000,
                           32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
  logic [31:0] L_R [8] = '{32'hC0800000, 32'h40C00000, 32'hC0C00000, 32'h40800000,
                           32'h41C80000, 32'h42100000, 32'h42440000, 32'h42800000};
  int run_len = 0, elem_a = 0, elem_b = 0, elem_z = 0, done_cnt = 0;
  bit run_bad = 1'b0;

  // ---------------- per-cycle checker ---------------------------------------
  logic        pa_stb = 1'b0, pa_x = 1'b0, pb_stb = 1'b0, pb_x = 1'b0;
  logic [31:0] pa_d, pb_d;

  always @(negedge clk) begin
    if (!rst_n) begin
      pa_stb = 1'b0; pb_stb = 1'b0;
    end else begin
      if (pa_stb && !pa_x) chk(mul_a_stb && mul_a == pa_d, "mul_a_hold", mul_a, pa_d);
      if (pb_stb && !pb_x) chk(mul_b_stb && mul_b == pb_d, "mul_b_hold", mul_b, pb_d);
      if (run_bad) chk(!(mul_a_stb || mul_b_stb), "stb_on_bad_len", {30'd0, mul_a_stb, mul_b_stb}, 0);
      if (prod_z_ack) chk(z_stb, "z_ack_before_stb", {31'd0, z_stb}, 1);
      if (mul_a_stb && a_ack) begin
        chk(elem_a == elem_z && elem_a < run_len && mul_a == exp_A[elem_a & 7], "a_xfer", mul_a, exp_A[elem_a & 7]);
        elem_a++;
      end
      if (mul_b_stb && b_ack) begin
        chk(elem_b == elem_z && elem_b < run_len && mul_b == exp_B[elem_b & 7], "b_xfer", mul_b, exp_B[elem_b & 7]);
        elem_b++;
      end
      if (z_stb && prod_z_ack) begin
        chk(elem_a == elem_z + 1 && elem_b == elem_z + 1 &&
            z == sp_mul(exp_A[elem_z & 7], exp_B[elem_z & 7]), "z_xfer", z, sp_mul(exp_A[elem_z & 7], exp_B[elem_z & 7]));
        elem_z++;
      end
      if (done) begin
        done_cnt++;
        chk(!busy && err == run_bad && elem_z == (run_bad ? 0 : run_len), "done_state",
            {29'd0, busy, err, 1'b0} | 32'(elem_z << 8), 32'(run_bad ? 0 : run_len) << 8 | {30'd0, run_bad, 1'b0});
      end
      pa_stb = mul_a_stb; pa_x = mul_a_stb & a_ack; pa_d = mul_a;
      pb_stb = mul_b_stb; pb_x = mul_b_stb & b_ack; pb_d = mul_b;
    end
  end

  // ---------------- stimulus tasks (called at a falling edge) ---------------
  task automatic wr(input logic sel, input int addr, input logic [31:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 3'(addr); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (sel) exp_B[addr] = d;
    else     exp_A[addr] = d;
  endtask

  task automatic load_lit();
    for (int i = 0; i < 8; i++) begin
      wr(1'b0, i, L_A[i]);
      wr(1'b1, i, L_B[i]);
    end
  endtask

  task automatic check_R(input string nm);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      chk(rd_data == exp_R[i], nm, rd_data, exp_R[i]);
    end
    @(negedge clk);
  endtask

  task automatic check_lit(input string nm);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      chk(rd_data == L_R[i], nm, rd_data, L_R[i]);
    end
    @(negedge clk);
  endtask

  task automatic run_vec(input int n);
    run_len = n; run_bad = (n == 0 || n > 8);
    elem_a = 0; elem_b = 0; elem_z = 0; done_cnt = 0;
    len_v = 4'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (run_bad) begin
      chk(!done, "bad_len_done_early", {31'd0, done}, 0);
      @(negedge clk);
      chk(done && err, "bad_len_done_err", {30'd0, done, err}, 3);
    end else begin
      chk(busy, "busy_rise", {31'd0, busy}, 1);
    end
    for (int c = 0; c < 3000 && done_cnt == 0; c++) @(negedge clk);
    chk(done_cnt != 0, "done_timeout", done_cnt, 1);
    if (!run_bad) for (int i = 0; i < n; i++) exp_R[i] = sp_mul(exp_A[i], exp_B[i]);
    repeat (3) @(negedge clk);
    chk(done_cnt == 1, "one_done_pulse", done_cnt, 1);
    chk(err == run_bad && !busy, "idle_err_busy", {30'd0, err, busy}, {30'd0, run_bad, 1'b0});
    check_R("R_readback");
  endtask

  // ---------------- main sequence -------------------------------------------
  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    len_v = '0; start = 1'b0; rd_addr = '0;
    for (int i = 0; i < 8; i++) begin exp_A[i] = '0; exp_B[i] = '0; exp_R[i] = '0; end
    repeat (2) @(negedge clk);
    chk({busy, done, err, mul_a_stb, mul_b_stb, prod_z_ack} == 6'd0 && mul_a == 0 && mul_b == 0,
        "reset_outputs", {26'd0, busy, done, err, mul_a_stb, mul_b_stb, prod_z_ack}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_R("reset_R");

    // 1: reference vector
    load_lit();
    run_vec(8);
    check_lit("t1_R");

    // 2: b ack delayed after a ack
    b_dly = 3;
    run_vec(8);
    check_lit("t2_R");

    // 3: late product strobe
    b_dly = 0; z_dly = 20;
    run_vec(8);
    check_lit("t3_R");
    z_dly = 3;

    // 4: illegal lengths
    run_vec(0);
    run_vec(9);
    check_lit("t4_R");

    // 5: start / wr_en pulsed while busy
    fork
      run_vec(8);
      begin
        repeat (15) @(negedge clk);
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 3'd7; wr_data = 32'hDEADBEEF;
        @(negedge clk);
        wr_sel = 1'b1; wr_addr = 3'd6;
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
      end
    join
    check_lit("t5_R");
    run_vec(8);
    check_lit("t5_rerun_R");

    // randomized vectors, lengths and handshake timing
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 8; i++) begin
        wr(1'b0, i, rnd_fp());
        wr(1'b1, i, rnd_fp());
      end
      ord = $urandom_range(0, 2); a_dly = $urandom_range(0, 3);
      b_dly = $urandom_range(0, 4); z_dly = $urandom_range(0, 6);
      run_vec($urandom_range(1, 8));
    end

    // 6: reset during ISSUE of element 3
    ord = 0; a_dly = 2; b_dly = 1; z_dly = 2;
    load_lit();
    run_len = 8; run_bad = 1'b0; elem_a = 0; elem_b = 0; elem_z = 0; done_cnt = 0;
    len_v = 4'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 2000 && !(elem_z == 3 && mul_a_stb); c++) @(negedge clk);
    chk(elem_z == 3 && mul_a_stb, "reach_issue_3", elem_z, 3);
    rst_n = 1'b0;
    #1;
    chk({busy, done, err, mul_a_stb, mul_b_stb, prod_z_ack} == 6'd0 && mul_a == 0 && mul_b == 0,
        "midrun_reset_outputs", {26'd0, busy, done, err, mul_a_stb, mul_b_stb, prod_z_ack}, 0);
    for (int i = 0; i < 8; i++) begin exp_A[i] = '0; exp_B[i] = '0; exp_R[i] = '0; end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_R("reset_R_cleared");
    a_dly = 0; b_dly = 0; z_dly = 3;
    load_lit();
    run_vec(8);
    check_lit("t6_R");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
